// File: rtl/dnn_layer_seq_if.sv
// Bundle of every handshake and bus signal around the layer sequencer:
// the upstream feature source, the weight ROM, the MAC datapath and the
// downstream result sink. The sequencer uses the slave view. The
// surrounding environment uses the master view.
interface dnn_layer_seq_if #(
    parameter int IN_SIZE  = 7,
    parameter int OUT_SIZE = 17,
    parameter int ADDR_W   = 5
);
    logic                    s_valid;
    logic                    s_ready;
    logic [4*IN_SIZE-1:0]    s_data;
    logic                    w_ren;
    logic [ADDR_W-1:0]       w_addr;
    logic [IN_SIZE-1:0]      w_rdata;
    logic                    mac_start;
    logic [4*IN_SIZE-1:0]    x_flat;
    logic [16*IN_SIZE-1:0]   w_flat;
    logic                    mac_ready;
    logic [4*OUT_SIZE-1:0]   mac_flat;
    logic                    m_valid;
    logic                    m_ready;
    logic [4*IN_SIZE-1:0]    m_data;

    modport master (
        output s_valid, s_data, w_rdata, mac_ready, mac_flat, m_ready,
        input  s_ready, w_ren, w_addr, mac_start, x_flat, w_flat, m_valid, m_data
    );

    modport slave (
        input  s_valid, s_data, w_rdata, mac_ready, mac_flat, m_ready,
        output s_ready, w_ren, w_addr, mac_start, x_flat, w_flat, m_valid, m_data
    );
endinterface

// File: rtl/dnn_layer_seq.sv
// Layer sequencer for the 4x4 fully-connected MAC datapath. It runs
// NUM_LAYERS layers per input vector on the single datapath. For each layer
// it loads 16 weights from the ROM, fires the datapath once, and then
// requantises the results (ReLU, arithmetic shift, clamp). The requantised
// values become the next layer's activations.
module dnn_layer_seq #(
    parameter int IN_SIZE    = 7,
    parameter int OUT_SIZE   = 17,
    parameter int NUM_LAYERS = 2,
    parameter int SHIFT      = 4,
    parameter int ADDR_W     = 5,
    localparam int LW        = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dnn_layer_seq_if.slave        bus,
    output logic                  busy,
    output logic [LW-1:0]         layer_idx
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LOAD_W   = 3'd1;
    localparam logic [2:0] FIRE     = 3'd2;
    localparam logic [2:0] WAIT_MAC = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    // Largest positive activation, held at MAC width so the clamp compares
    // at full precision before truncation.
    localparam logic signed [OUT_SIZE-1:0] ACT_MAX_WIDE =
        {{(OUT_SIZE-IN_SIZE+1){1'b0}}, {(IN_SIZE-1){1'b1}}};
    localparam logic signed [IN_SIZE-1:0]  ACT_MAX = {1'b0, {(IN_SIZE-1){1'b1}}};

    logic [2:0]                  state;
    logic [4:0]                  k;          // ROM load counter, 0..16
    logic                        m_valid_r;
    logic signed [IN_SIZE-1:0]   x_reg [4];
    logic signed [IN_SIZE-1:0]   w_reg [16];
    logic                        rd_phase;
    logic [ADDR_W-1:0]           addr_base;

    // ReLU, then arithmetic shift, then clamp to the largest positive activation.
    function automatic logic signed [IN_SIZE-1:0] requant(
        input logic signed [OUT_SIZE-1:0] v
    );
        logic signed [OUT_SIZE-1:0] sh;
        sh = v >>> SHIFT;
        if (v < 0)
            requant = '0;
        else if (sh > ACT_MAX_WIDE)
            requant = ACT_MAX;
        else
            requant = sh[IN_SIZE-1:0];
    endfunction

    // Sequencer state, counters and the activation/weight registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k         <= '0;
            layer_idx <= '0;
            m_valid_r <= 1'b0;
            for (int i = 0; i < 4; i++)  x_reg[i] <= '0;
            for (int s = 0; s < 16; s++) w_reg[s] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.s_valid) begin
                        for (int i = 0; i < 4; i++)
                            x_reg[i] <= bus.s_data[i*IN_SIZE +: IN_SIZE];
                        layer_idx <= '0;
                        k         <= '0;
                        state     <= LOAD_W;
                    end
                end
                LOAD_W: begin
                    // ROM data lags its address by one cycle, so slot k-1 lands at k.
                    if (k != 5'd0)
                        w_reg[4'(k - 5'd1)] <= bus.w_rdata;
                    if (k == 5'd16)
                        state <= FIRE;
                    else
                        k <= k + 5'd1;
                end
                FIRE: begin
                    state <= WAIT_MAC;
                end
                WAIT_MAC: begin
                    if (bus.mac_ready) begin
                        for (int j = 0; j < 4; j++)
                            x_reg[j] <= requant(bus.mac_flat[j*OUT_SIZE +: OUT_SIZE]);
                        if (layer_idx == LW'(NUM_LAYERS - 1)) begin
                            state <= DONE;
                        end else begin
                            layer_idx <= layer_idx + 1'b1;
                            k         <= '0;
                            state     <= LOAD_W;
                        end
                    end
                end
                DONE: begin
                    // The result is presented one cycle after DONE is entered,
                    // and it is held until the sink takes it.
                    if (m_valid_r && bus.m_ready) begin
                        m_valid_r <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        m_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Handshake, ROM addressing and datapath control decoded from the state.
    always_comb begin
        rd_phase      = (state == LOAD_W) && !k[4];
        addr_base     = ADDR_W'({layer_idx, 4'b0000});
        bus.s_ready   = (state == IDLE);
        bus.w_ren     = rd_phase;
        bus.w_addr    = rd_phase ? (addr_base + ADDR_W'(k)) : '0;
        bus.mac_start = (state == FIRE);
        bus.m_valid   = m_valid_r;
        busy          = (state != IDLE);
    end

    // Flatten the activation and weight registers onto the buses.
    always_comb begin
        bus.x_flat = '0;
        bus.m_data = '0;
        bus.w_flat = '0;
        for (int i = 0; i < 4; i++) begin
            bus.x_flat[i*IN_SIZE +: IN_SIZE] = x_reg[i];
            bus.m_data[i*IN_SIZE +: IN_SIZE] = x_reg[i];
        end
        for (int s = 0; s < 16; s++)
            bus.w_flat[s*IN_SIZE +: IN_SIZE] = w_reg[s];
    end

endmodule

// File: doc/dnn_layer_seq.md
# dnn_layer_seq

Sequencer for the 4×4 fully-connected MAC layer datapath. It runs a NUM_LAYERS-deep network by time-multiplexing that single datapath. For each layer it streams that layer's 16 weights from an external weight ROM into registers, fires the datapath, and applies ReLU plus requantisation to the MAC results. The requantised values become the next layer's inputs. It sits between the upstream feature source (valid/ready), the weight ROM, and the MAC datapath, and presents the final 4-element vector downstream (valid/ready).

## Interface
- IN_SIZE, 7, signed bit width of activations and weights
- OUT_SIZE, 17, signed bit width of datapath MAC results
- NUM_LAYERS, 2, layers executed per input vector (≥1)
- SHIFT, 4, right-shift applied to ReLU'd MAC result before clamping
- ADDR_W, 5, weight ROM address width; must satisfy 2^ADDR_W ≥ 16·NUM_LAYERS
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- s_valid  in  1  input vector valid
- s_ready  out  1  block can accept an input vector
- s_data  in  4·IN_SIZE  x0..x3; xi at [i·IN_SIZE +: IN_SIZE]
- w_ren  out  1  weight ROM read enable
- w_addr  out  ADDR_W  weight ROM address
- w_rdata  in  IN_SIZE  ROM data, valid exactly one cycle after a w_ren cycle
- mac_start  out  1  drives the datapath's in_ready
- x_flat  out  4·IN_SIZE  datapath inputs x0..x3, same packing as s_data
- w_flat  out  16·IN_SIZE  datapath weights; w_ij (input i → output j) at [(4i+j)·IN_SIZE +: IN_SIZE]
- mac_ready  in  1  datapath result valid
- mac_flat  in  4·OUT_SIZE  datapath outputs out0..out3; outj at [j·OUT_SIZE +: OUT_SIZE]
- m_valid  out  1  result vector valid
- m_ready  in  1  downstream accepts result
- m_data  out  4·IN_SIZE  final-layer activations, same packing as s_data
- busy  out  1  high in every state except IDLE
- layer_idx  out  clog2(NUM_LAYERS) (min 1)  current layer

## Operation
- States: IDLE, LOAD_W, FIRE, WAIT_MAC, DONE.
- IDLE
  - s_ready=1.
  - When s_valid=1, capture s_data into the x registers, clear layer_idx, clear the load counter, and go to LOAD_W.
- LOAD_W
  - Counter k runs 0..16.
  - For k≤15: w_ren=1 and w_addr = 16·layer_idx + k.
  - For k≥1: w_rdata is written into w_flat slot k-1.
  - After k=16, go to FIRE.
- FIRE
  - mac_start=1 for exactly one cycle, then go to WAIT_MAC.
  - x_flat and w_flat stay stable from FIRE until mac_ready is seen.
- WAIT_MAC
  - Waits indefinitely for mac_ready.
  - On mac_ready, each outj is requantised: y = (outj<0) ? 0 : min(outj >>> SHIFT, 2^(IN_SIZE-1)−1). The result is written to xj.
  - If layer_idx = NUM_LAYERS−1, go to DONE. Otherwise increment layer_idx, clear k, and go to LOAD_W.
- DONE
  - m_valid=1 and m_data = x registers, both held stable until m_ready=1.
  - On m_valid&m_ready, go to IDLE.
- mac_ready in any state other than WAIT_MAC is ignored.
- s_valid is ignored while s_ready=0.
- Arithmetic: the shift is arithmetic on OUT_SIZE bits. The clamp compares at full width before truncating to IN_SIZE.

## Timing
- Reset values:
  - state = IDLE.
  - Outputs: s_ready=1; w_ren=0; w_addr=0; mac_start=0; m_valid=0; busy=0; layer_idx=0.
  - x_flat, w_flat and m_data = 0.
- Reset asserted mid-operation aborts immediately; no partial result is ever presented.
- Per layer: 17 cycles in LOAD_W, 1 in FIRE, then WAIT_MAC until mac_ready. The datapath answers one cycle after mac_start, so a layer takes 19 cycles.
- If s_valid&s_ready at edge E0, m_valid rises at edge E0 + 19·NUM_LAYERS + 1 (E0+39 at defaults).
- Earliest next acceptance is the edge after the m_valid&m_ready handshake. s_ready is low in the cycle the result is consumed.
- With m_ready held high, m_valid is high for exactly one cycle.

## Test plan
- Identity pass-through
  - Stimulus: ROM holds w_ii=16, all else 0, for both layers; s_data = (5, −3, 63, 0).
  - Required: m_data = (5, 0, 63, 0); m_valid rises at E0+39.
- Saturation
  - Stimulus: all weights 63; x = (63, 63, 63, 63).
  - Required: layer 1 outj = 15876, and every output clamps to 63.
  - Required: final m_data = (63, 63, 63, 63).
- Negative clamp
  - Stimulus: all weights −64; x = (10, 10, 10, 10).
  - Required: m_data = (0, 0, 0, 0).
- ROM sequencing
  - Check: w_addr = 0..15 during layer 0 and 16..31 during layer 1, with w_ren high exactly 16 cycles per layer.
  - Check: mac_start pulses once per layer.
- Backpressure
  - Stimulus: hold m_ready=0 for 10 cycles; drive s_valid=1 throughout.
  - Required: m_data stable, s_ready=0, and no second input captured.
  - Required: after m_ready, the next vector is accepted one cycle later.
- Reset mid-run
  - Stimulus: assert rst_n=0 during layer-1 LOAD_W.
  - Required: all outputs return to reset values asynchronously; a fresh vector afterwards completes correctly.
- Spurious mac_ready
  - Stimulus: pulse mac_ready during LOAD_W.
  - Required: ignored; x registers unchanged and sequencing unaffected.
